// File: rtl/s0_rs_enc_lfsr.sv
// Systematic RS(DATA_LEN+4, DATA_LEN) encoder over GF(2^8), poly 0x11D, t=2.
// Streams message symbols through, then appends parity P3..P0 from a 4-stage GF LFSR.
module s0_rs_enc_lfsr #(
    parameter int unsigned DATA_LEN = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_sop,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_sop,
    output logic       dout_eop,
    output logic       enc_done,
    output logic       enc_err
);
    localparam int unsigned     SYM_W    = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_LEN);
    localparam bit              ONE_SYM  = (DATA_LEN == 1);
    localparam logic [SYM_W-1:0] G3 = 8'h0F;
    localparam logic [SYM_W-1:0] G2 = 8'h36;
    localparam logic [SYM_W-1:0] G1 = 8'h78;
    localparam logic [SYM_W-1:0] G0 = 8'h40;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b100
    } state_t;

    state_t state, state_nxt;

    logic             accept, sop_acc, load;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]       pidx, pidx_nxt;
    logic [SYM_W-1:0] r3, r2, r1, r0;
    logic [SYM_W-1:0] r3_nxt, r2_nxt, r1_nxt, r0_nxt;
    logic [SYM_W-1:0] fb, b2, b1, b0;
    logic [SYM_W-1:0] dout_nxt;
    logic             dout_valid_nxt, dout_sop_nxt, dout_eop_nxt, enc_err_nxt;

    // GF(2^8) multiply; with a constant b this reduces to a small XOR network.
    function automatic logic [SYM_W-1:0] gmul(input logic [SYM_W-1:0] a,
                                              input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[SYM_W-2:0], 1'b0} ^ (x[SYM_W-1] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    assign din_ready = (state != PARITY);
    assign accept    = din_valid & din_ready;
    assign sop_acc   = accept & din_sop;
    assign load      = sop_acc | (accept & (state == DATA));
    assign cnt_inc   = cnt + CNT_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (sop_acc) state_nxt = ONE_SYM ? PARITY : DATA;
            end
            DATA: begin
                if (sop_acc)                              state_nxt = ONE_SYM ? PARITY : DATA;
                else if (accept && (cnt_inc == LAST_CNT)) state_nxt = PARITY;
            end
            PARITY: begin
                if (pidx == 2'd3) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values; a sop restarts the LFSR from zero in the same cycle
    always_comb begin
        cnt_nxt        = cnt;
        pidx_nxt       = pidx;
        r3_nxt         = r3;
        r2_nxt         = r2;
        r1_nxt         = r1;
        r0_nxt         = r0;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        dout_sop_nxt   = 1'b0;
        dout_eop_nxt   = 1'b0;
        enc_err_nxt    = 1'b0;
        b2             = din_sop ? 8'h00 : r2;
        b1             = din_sop ? 8'h00 : r1;
        b0             = din_sop ? 8'h00 : r0;
        fb             = din ^ (din_sop ? 8'h00 : r3);
        if (load) begin
            r3_nxt         = b2 ^ gmul(fb, G3);
            r2_nxt         = b1 ^ gmul(fb, G2);
            r1_nxt         = b0 ^ gmul(fb, G1);
            r0_nxt         = gmul(fb, G0);
            dout_nxt       = din;
            dout_valid_nxt = 1'b1;
            dout_sop_nxt   = din_sop;
            enc_err_nxt    = din_sop & (state == DATA);
            cnt_nxt        = din_sop ? CNT_W'(1) : cnt_inc;
            pidx_nxt       = 2'd0;
        end else if (state == PARITY) begin
            dout_nxt       = r3;
            r3_nxt         = r2;
            r2_nxt         = r1;
            r1_nxt         = r0;
            r0_nxt         = 8'h00;
            dout_valid_nxt = 1'b1;
            dout_eop_nxt   = (pidx == 2'd3);
            pidx_nxt       = pidx + 2'd1;
            if (pidx == 2'd3) cnt_nxt = '0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            pidx       <= '0;
            r3         <= '0;
            r2         <= '0;
            r1         <= '0;
            r0         <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            enc_done   <= 1'b0;
            enc_err    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            pidx       <= pidx_nxt;
            r3         <= r3_nxt;
            r2         <= r2_nxt;
            r1         <= r1_nxt;
            r0         <= r0_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            dout_sop   <= dout_sop_nxt;
            dout_eop   <= dout_eop_nxt;
            enc_done   <= dout_eop_nxt;
            enc_err    <= enc_err_nxt;
        end
    end

endmodule

// File: tb/tb_s0_rs_enc_lfsr.sv
// Bench for s0_rs_enc_lfsr: hand vectors on a DATA_LEN=1 instance, syndrome-checked
// codewords on a DATA_LEN=16 instance (bubbles, back-to-back, abort, mid-frame reset).
module tb_s0_rs_enc_lfsr;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] din_a, dout_a;
    logic       v_a, sop_a, ready_a, ov_a, osop_a, oeop_a, done_a, err_a;
    logic [7:0] din_b, dout_b;
    logic       v_b, sop_b, ready_b, ov_b, osop_b, oeop_b, done_b, err_b;

    s0_rs_enc_lfsr #(.DATA_LEN(1), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(v_a), .din_sop(sop_a),
        .din_ready(ready_a), .dout(dout_a), .dout_valid(ov_a), .dout_sop(osop_a),
        .dout_eop(oeop_a), .enc_done(done_a), .enc_err(err_a)
    );

    s0_rs_enc_lfsr #(.DATA_LEN(16), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(v_b), .din_sop(sop_b),
        .din_ready(ready_b), .dout(dout_b), .dout_valid(ov_b), .dout_sop(osop_b),
        .dout_eop(oeop_b), .enc_done(done_b), .enc_err(err_b)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference GF(2^8) arithmetic: carry-less product then reduction by 0x11D
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11D << (i - 8));
        return p[7:0];
    endfunction

    logic [7:0] cw [0:31];
    logic [7:0] msg [0:15];
    int cw_len = 0;
    int n_eop = 0;
    int cyc = 0;
    int last_eop_cyc = -100;
    int last_gap = 0;

    // Horner evaluation of the captured codeword at alpha^j (first symbol = highest power)
    function automatic logic [7:0] syndrome(input int j);
        logic [7:0] s;
        logic [7:0] a;
        a = 8'(1 << j);
        s = 8'h00;
        for (int i = 0; i < 20; i++) s = gf_mul(s, a) ^ cw[i];
        return s;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Codeword collector on the DATA_LEN=16 instance
    initial forever begin
        @(negedge clk);
        if (ov_b) begin
            if (osop_b) begin
                cw_len   = 0;
                last_gap = cyc - last_eop_cyc;
            end
            if (cw_len < 32) begin
                cw[cw_len] = dout_b;
                cw_len++;
            end
            if (oeop_b) begin
                chk("cw_len", 32'(cw_len), 32'd20);
                chk("done_with_eop", 32'(done_b), 32'd1);
                for (int j = 0; j < 4; j++)
                    chk($sformatf("syndrome_S%0d", j), 32'(syndrome(j)), 32'h0);
                n_eop++;
                last_eop_cyc = cyc;
            end
        end
    end

    task automatic enc_a(input logic [7:0] d, input logic [39:0] exp);
        chk("a_ready_idle", 32'(ready_a), 32'd1);
        din_a = d; sop_a = 1'b1; v_a = 1'b1;
        @(negedge clk);
        v_a = 1'b0; sop_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("a_dout%0d", k), 32'(dout_a), 32'(exp[39-8*k -: 8]));
            chk("a_valid", 32'(ov_a), 32'd1);
            chk("a_sop", 32'(osop_a), 32'(k == 0));
            chk("a_eop", 32'(oeop_a), 32'(k == 4));
            chk("a_done", 32'(done_a), 32'(k == 4));
            chk("a_ready", 32'(ready_a), 32'(k == 4));
            @(negedge clk);
        end
        chk("a_valid_after", 32'(ov_a), 32'd0);
    endtask

    task automatic send_b(input logic [7:0] d, input logic sop, input int bubbles);
        int guard;
        v_b = 1'b0;
        repeat (bubbles) @(negedge clk);
        din_b = d; sop_b = sop; v_b = 1'b1;
        guard = 0;
        while (!ready_b && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) chk("ready_wait", 32'(ready_b), 32'd1);
        @(negedge clk);
        v_b = 1'b0; sop_b = 1'b0;
    endtask

    task automatic send_frame(input int first, input int max_bub, input int first_bub);
        for (int i = first; i < 16; i++)
            send_b(msg[i], i == 0, (i == 0) ? first_bub : int'($urandom_range(max_bub, 0)));
    endtask

    task automatic wait_eop(input int target);
        int guard;
        guard = 0;
        while (n_eop < target && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 60) chk("eop_wait", 32'(n_eop), 32'(target));
        @(negedge clk);
    endtask

    task automatic chk_msg(input string tag);
        for (int i = 0; i < 16; i++) chk($sformatf("%s_msg%0d", tag, i), 32'(cw[i]), 32'(msg[i]));
    endtask

    initial begin
        int n, e0;
        rst = 1'b1;
        din_a = '0; v_a = 1'b0; sop_a = 1'b0;
        din_b = '0; v_b = 1'b0; sop_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout_a", 32'(dout_a), 32'h0);
        chk("rst_valid_a", 32'(ov_a), 32'd0);
        chk("rst_ready_a", 32'(ready_a), 32'd1);
        chk("rst_dout_b", 32'(dout_b), 32'h0);
        chk("rst_valid_b", 32'(ov_b), 32'd0);
        chk("rst_ready_b", 32'(ready_b), 32'd1);
        chk("rst_flags_b", 32'({oeop_b, done_b, err_b, osop_b}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single-symbol codewords: g(x) coefficients, then scaled by 2
        enc_a(8'h01, 40'h01_0F_36_78_40);
        enc_a(8'h02, 40'h02_1E_6C_F0_80);

        // Symbol without sop in IDLE is dropped
        din_a = 8'h55; v_a = 1'b1; sop_a = 1'b0;
        @(negedge clk);
        v_a = 1'b0;
        chk("drop_no_sop", 32'(ov_a), 32'd0);
        @(negedge clk);

        // All-zero message
        for (int i = 0; i < 16; i++) msg[i] = 8'h00;
        send_frame(0, 0, 0);
        n = 0;
        while (!ready_b && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("ready_low_cycles", 32'(n), 32'd4);
        wait_eop(1);
        for (int i = 16; i < 20; i++) chk($sformatf("zero_par%0d", i - 16), 32'(cw[i]), 32'h0);

        // Two back-to-back random frames with bubbles
        for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
        send_frame(0, 2, 1);
        for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
        send_frame(0, 2, 0);
        wait_eop(3);
        chk("gapless_sop", 32'(last_gap), 32'd1);
        chk_msg("b2b");

        // Abort after 5 symbols, then a full new frame
        e0 = n_eop;
        for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) send_b(msg[i], i == 0, 0);
        chk("no_err_before_abort", 32'(err_b), 32'd0);
        for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
        send_b(msg[0], 1'b1, 0);
        chk("abort_err", 32'(err_b), 32'd1);
        chk("abort_sop", 32'(osop_b), 32'd1);
        send_b(msg[1], 1'b0, 0);
        chk("abort_err_pulse", 32'(err_b), 32'd0);
        send_frame(2, 1, 0);
        wait_eop(e0 + 1);
        repeat (3) @(negedge clk);
        chk("abort_eop_count", 32'(n_eop), 32'(e0 + 1));
        chk_msg("abort");

        // Reset while P2 is on dout
        e0 = n_eop;
        for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
        send_frame(0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("p2_valid", 32'(ov_b), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ov_b), 32'd0);
        chk("midrst_ready", 32'(ready_b), 32'd1);
        chk("midrst_dout", 32'(dout_b), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_no_eop", 32'(n_eop), 32'(e0));
        for (int i = 0; i < 16; i++) msg[i] = 8'($urandom);
        send_frame(0, 1, 0);
        wait_eop(e0 + 1);
        chk_msg("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
